iter_comparator: RTL and testbench
==================================

# iter_comparator

Parametrised, multi-cycle branch comparator for the pipelined CPU's branch-resolution path. It evaluates the six RISC-V branch conditions on WIDTH-bit operands, scanning CHUNK bits per cycle from the MSB down, and stops early at the first differing chunk. Operands enter and results leave through valid/ready handshakes, so it can sit behind the EX-stage operand mux and stall the pipeline while busy.

## Interface
- WIDTH, 32, operand width in bits
- CHUNK, 8, bits compared per cycle; WIDTH % CHUNK != 0 is an elaboration error; NCHUNK = WIDTH/CHUNK
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- a_val  in  WIDTH  operand A
- b_val  in  WIDTH  operand B
- ctrl  in  3  condition (funct3): 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  1  condition outcome

## Operation
- States: IDLE, SCAN, DONE. in_ready = (state == IDLE).
- IDLE: on in_valid && in_ready, register a_val, b_val, ctrl; set chunk index k = NCHUNK-1 (MSB chunk); go to SCAN. Legal or illegal ctrl, always go to SCAN.
- SCAN, illegal ctrl: result_reg = 0, go to DONE (one SCAN cycle).
- SCAN, legal ctrl: compare chunk k of A and B. For signed ops (LT/GE), the MSB of chunk NCHUNK-1 is inverted on both operands before the unsigned chunk compare; all other chunks are unsigned.
  - Chunks differ: gt/lt decided; compute result, go to DONE.
  - Chunks equal, k > 0: k <= k-1, stay in SCAN.
  - Chunks equal, k == 0: operands equal; compute result, go to DONE.
- Result mapping: EQ = equal; NE = !equal; LT/LTU = lt; GE/GEU = !lt (equal gives GE/GEU = 1).
- DONE: out_valid = 1, result held stable. On out_ready, go to IDLE. in_valid is ignored in SCAN and DONE.
- NCHUNK == 1: every legal request completes in one SCAN cycle.
- Reset (rst_n low at a clock edge): state = IDLE, k = NCHUNK-1, result_reg = 0, any in-flight request is dropped with no output.

## Timing
- Reset values (after the reset edge): in_ready = 1, out_valid = 0, result = 0.
- Latency, accept edge to out_valid high: j+1 cycles, where j is the number of leading equal chunks (0 ≤ j < NCHUNK). Equal operands take NCHUNK cycles. Illegal ctrl takes 1 cycle.
- out_valid and result are registered, with no combinational path from inputs.
- Handshake completes on the edge where out_valid && out_ready. in_ready rises the following cycle, so the minimum initiation interval is latency + 2 cycles.
- out_valid, once high, stays high and result stays unchanged until the handshake or reset.

## Test plan
- WIDTH=32, CHUNK=8, EQ, a = b = 0x12345678, out_ready = 1 → out_valid 4 cycles after accept, result = 1; NE with the same operands → result = 0.
- LT with a = 0x80000000, b = 0x00000001 → latency 1, result = 1; LTU with the same operands → latency 1, result = 0; GE → 0; GEU → 1.
- GEU with a = 0x000000FF, b = 0x000000FE → latency 4, result = 1. LT with a = 0xFFFFFFFE, b = 0xFFFFFFFF → latency 4, result = 1.
- Backpressure: EQ completes, out_ready held low 5 cycles while in_valid = 1 with new operands → out_valid and result stay constant, in_ready = 0, the new request is not accepted. out_ready = 1 → return to IDLE; the new request is accepted the next cycle.
- Reset mid-scan: accept EQ of equal operands, drive rst_n = 0 at the 2nd SCAN cycle → next edge gives out_valid = 0, in_ready = 1, result = 0, and no result is ever produced for that request.
- Illegal ctrl = 010, any operands → out_valid after 1 cycle, result = 0; then a legal LTU request (a = 1, b = 2) → result = 1.

Source files
------------

// File: rtl/iter_comparator.sv
// iter_comparator
// Multi-cycle RISC-V branch comparator. Operands are scanned CHUNK bits per
// cycle from the most significant chunk downwards. The scan stops at the
// first chunk that differs, so the latency depends on the data. Requests
// and results each use a valid/ready handshake.

module iter_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_TOP  = KW'(NCHUNK - 1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    // Operands must split into a whole number of chunks.
    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
            $error("iter_comparator: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // funct3 encodings of the branch conditions
    localparam logic [2:0] F3_EQ  = 3'b000;
    localparam logic [2:0] F3_NE  = 3'b001;
    localparam logic [2:0] F3_LT  = 3'b100;
    localparam logic [2:0] F3_GE  = 3'b101;
    localparam logic [2:0] F3_LTU = 3'b110;
    localparam logic [2:0] F3_GEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q,  state_d;
    logic [KW-1:0]    k_q,      k_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [2:0]       ctrl_q,   ctrl_d;
    logic             result_q, result_d;

    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;
    logic             signed_op_s;
    logic             legal_s;

    // Extracts chunk k. For signed compares, the sign bit of the top chunk
    // is flipped so that an unsigned compare orders two's-complement values.
    function automatic logic [CHUNK-1:0] get_chunk(
        input logic [WIDTH-1:0] v,
        input logic [KW-1:0]    k,
        input logic             flip_msb
    );
        logic [CHUNK-1:0] c;
        c = v[k*CHUNK +: CHUNK];
        if (flip_msb && (k == K_TOP)) begin
            c[CHUNK-1] = ~c[CHUNK-1];
        end
        return c;
    endfunction

    // True for the six defined branch conditions.
    function automatic logic is_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_EQ, F3_NE, F3_LT, F3_GE, F3_LTU, F3_GEU: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Maps the equal / less-than outcome onto the requested condition.
    function automatic logic map_result(
        input logic [2:0] f3,
        input logic       eq,
        input logic       lt
    );
        logic r;
        case (f3)
            F3_EQ:            r = eq;
            F3_NE:            r = ~eq;
            F3_LT,  F3_LTU:   r = lt;
            F3_GE,  F3_GEU:   r = ~lt;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    // Select the current chunk of each operand. Signed ops use a flipped top bit.
    always_comb begin
        signed_op_s = (ctrl_q[2:1] == 2'b10);
        legal_s     = is_legal(ctrl_q);
        chunk_a_s   = get_chunk(a_q, k_q, signed_op_s);
        chunk_b_s   = get_chunk(b_q, k_q, signed_op_s);
    end

    // Next-state logic: accept, scan one chunk per cycle, then hold the result.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_val;
                    b_d     = b_val;
                    ctrl_d  = ctrl;
                    k_d     = K_TOP;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (!legal_s) begin
                    result_d = 1'b0;
                    state_d  = DONE;
                end else if (chunk_a_s != chunk_b_s) begin
                    // The first differing chunk decides the ordering.
                    result_d = map_result(ctrl_q, 1'b0, (chunk_a_s < chunk_b_s));
                    state_d  = DONE;
                end else if (k_q != K_ZERO) begin
                    k_d     = k_q - K_ONE;
                    state_d = SCAN;
                end else begin
                    // Every chunk matched, so the operands are equal.
                    result_d = map_result(ctrl_q, 1'b1, 1'b0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= K_TOP;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= 3'b000;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_iter_comparator.sv
// Scoreboard bench for iter_comparator. The driver issues requests. The
// monitor pushes a reference expectation on each accept. It then pops and
// compares that expectation when out_valid rises, checking both the result
// and the latency.

module tb_iter_comparator;

    localparam int W   = 32;
    localparam int CH  = 8;
    localparam int NCH = W / CH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_val;
    logic [W-1:0]  b_val;
    logic [2:0]    ctrl;
    logic          out_valid;
    logic          out_ready;
    logic          result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic res;
        int   lat;
        int   acc;
    } exp_t;

    exp_t sb[$];

    iter_comparator #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_val     (a_val),
        .b_val     (b_val),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: branch outcome from plain arithmetic. Latency comes from the
    // position of the highest differing bit.
    function automatic void model(input logic [2:0] c, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic res, output int lat);
        logic [W-1:0] x;
        int p;
        x = a ^ b;
        p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        lat = (p < 0) ? NCH : (NCH - p / CH);
        case (c)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = ($signed(a) <  $signed(b));
            3'b101:  res = ($signed(a) >= $signed(b));
            3'b110:  res = (a <  b);
            3'b111:  res = (a >= b);
            default: begin res = 1'b0; lat = 1; end
        endcase
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    logic prev_valid = 1'b0;
    logic held_res   = 1'b0;
    logic rst_seen   = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            rst_seen   = 1'b1;
            prev_valid = 1'b0;
        end else begin
            if (rst_seen) begin
                chk("reset_in_ready",  in_ready,  1);
                chk("reset_out_valid", out_valid, 0);
                chk("reset_result",    result,    0);
                rst_seen = 1'b0;
            end
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result",  result,    e.res);
                    chk("latency", cyc - e.acc, e.lat);
                    held_res = result;
                end
            end else if (out_valid) begin
                chk("result_hold", result, held_res);
            end
            if (out_valid) chk("in_ready_busy", in_ready, 0);
            prev_valid = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                model(ctrl, a_val, b_val, e.res, e.lat);
                e.acc = cyc + 1;
                sb.push_back(e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Issue one request. A non-zero hold keeps out_ready low that many cycles
    // while a second request waits on in_valid. That request is accepted after
    // the handshake.
    task automatic send(input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
        int t;
        ctrl = c; a_val = a; b_val = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        t = 0;
        while (!in_ready && t < 50) begin tick; t++; end
        chk("wait_in_ready", (t < 50), 1);
        tick;
        if (hold > 0) begin
            ctrl = 3'b110; a_val = $urandom; b_val = $urandom;
        end else begin
            in_valid = 1'b0;
        end
        t = 0;
        while (!out_valid && t < 50) begin tick; t++; end
        chk("wait_out_valid", (t < 50), 1);
        if (hold > 0) begin
            repeat (hold) tick;
            out_ready = 1'b1;
            tick;
            tick;
            in_valid = 1'b0;
            t = 0;
            while (!out_valid && t < 50) begin tick; t++; end
            chk("wait_out_valid_2", (t < 50), 1);
        end
        tick;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ctrl = 3'b000; a_val = '0; b_val = '0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;

        send(3'b000, 32'h12345678, 32'h12345678, 0);
        send(3'b001, 32'h12345678, 32'h12345678, 0);
        send(3'b100, 32'h80000000, 32'h00000001, 0);
        send(3'b110, 32'h80000000, 32'h00000001, 0);
        send(3'b101, 32'h80000000, 32'h00000001, 0);
        send(3'b111, 32'h80000000, 32'h00000001, 0);
        send(3'b111, 32'h000000FF, 32'h000000FE, 0);
        send(3'b100, 32'hFFFFFFFE, 32'hFFFFFFFF, 0);
        send(3'b000, 32'hCAFEF00D, 32'hCAFEF00D, 5);

        // Reset during the second scan cycle drops the request.
        ctrl = 3'b000; a_val = 32'h0BADBEEF; b_val = 32'h0BADBEEF; in_valid = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (8) tick;

        send(3'b010, $urandom, $urandom, 0);
        send(3'b011, $urandom, $urandom, 0);
        send(3'b110, 32'h00000001, 32'h00000002, 0);

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            m = 32'hFFFFFFFF >> (8 * $urandom_range(0, 4));
            send(3'($urandom_range(0, 7)), a, a ^ ($urandom & m), $urandom_range(0, 2));
        end

        repeat (10) tick;
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
